// File: rtl/mux_arb_reg_pkg.sv
// Shared arbiter state encoding and source identifiers for the mux/arbiter/register slice.
// The grant helper lives here so the tie-break rule is defined in one place.
package mux_arb_reg_pkg;

    typedef enum logic {
        PREF_A = 1'b0,
        PREF_B = 1'b1
    } arb_state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // B wins only when it is alone, or on a tie when B is the preferred source.
    function automatic logic grant_b(input arb_state_e state, input logic aValid, input logic bValid);
        logic result;
        result = 1'b0;
        if (aValid && bValid) begin
            result = (state == PREF_B);
        end else begin
            result = bValid;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_arb_reg_mux.sv
// Plain combinational 2:1 data multiplexer: i_sel = 0 passes i_d0, i_sel = 1 passes i_d1.
module mux_arb_reg_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mux_arb_reg.sv
// Two-source round-robin arbiter feeding a single registered output stage.
// One beat per cycle is accepted whenever the output register is empty or being drained.
module mux_arb_reg
    import mux_arb_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic [15:0]      xfer_cnt
);

    arb_state_e       r_state;
    arb_state_e       w_nextState;
    logic             r_outValid;
    logic [WIDTH-1:0] r_outData;
    logic             r_outSrc;
    logic [15:0]      r_xferCnt;

    logic             w_accept;
    logic             w_grantA;
    logic             w_grantB;
    logic             w_take;
    logic [WIDTH-1:0] w_muxOut;

    // rst_n gates accept so both readies stay low for the whole reset interval.
    assign w_accept = rst_n && (!r_outValid || out_ready);
    assign w_take   = w_accept && (w_grantA || w_grantB);

    always_comb begin
        w_grantB    = grant_b(r_state, a_valid, b_valid);
        w_grantA    = a_valid && !w_grantB;
        w_nextState = r_state;
        if (w_take) begin
            w_nextState = w_grantA ? PREF_B : PREF_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PREF_A;
        end else begin
            r_state <= w_nextState;
        end
    end

    mux_arb_reg_mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_d0  (a_data),
        .i_d1  (b_data),
        .i_sel (sel),
        .o_y   (w_muxOut)
    );

    // A new beat has priority over draining, which gives back-to-back throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outSrc   <= SRC_A;
            r_xferCnt  <= 16'h0000;
        end else if (w_take) begin
            r_outValid <= 1'b1;
            r_outData  <= w_muxOut;
            r_outSrc   <= w_grantB ? SRC_B : SRC_A;
            r_xferCnt  <= r_xferCnt + 16'h0001;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign sel       = w_grantB;
    assign a_ready   = w_accept && w_grantA;
    assign b_ready   = w_accept && w_grantB;
    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign out_src   = r_outSrc;
    assign xfer_cnt  = r_xferCnt;

endmodule

// File: doc/mux_arb_reg.md
MUX_ARB_REG -- requirements
Module: mux_arb_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of both sources and the output.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port a_data  input  WIDTH  source A payload.
REQ-005 SHALL have port a_valid  input  1  source A offers a_data.
REQ-006 SHALL have port a_ready  output  1  source A beat accepted this cycle.
REQ-007 SHALL have port b_data  input  WIDTH  source B payload.
REQ-008 SHALL have port b_valid  input  1  source B offers b_data.
REQ-009 SHALL have port b_ready  output  1  source B beat accepted this cycle.
REQ-010 SHALL have port sel  output  1  combinational select for the 2:1 mux: 0 = A, 1 = B.
REQ-011 SHALL have port out_data  output  WIDTH  registered winning payload.
REQ-012 SHALL have port out_valid  output  1  out_data holds an unconsumed beat.
REQ-013 SHALL have port out_ready  input  1  downstream consumes out_data when out_valid.
REQ-014 SHALL have port out_src  output  1  source of the held beat: 0 = A, 1 = B.
REQ-015 SHALL have port xfer_cnt  output  16  count of accepted input beats.

Function
REQ-016 SHALL define accept = !out_valid || out_ready, computed combinationally each cycle.
REQ-017 SHALL grant A when only a_valid is high, B when only b_valid is high, and no source when neither is high.
REQ-018 SHALL, when a_valid and b_valid are both high, grant the source opposite to last_grant (round-robin).
REQ-019 SHALL drive sel = 1 only when B is granted, otherwise 0, including when there is no grant.
REQ-020 SHALL drive a_ready = accept && (A granted) and b_ready = accept && (B granted); at most one is high in any cycle.
REQ-021 SHALL, on an accepted beat, load out_data from the mux output, set out_src to the granted source, and set out_valid = 1 on the next edge (latency 1 cycle).
REQ-022 SHALL, on out_valid && out_ready with no new accepted beat, clear out_valid on the next edge.
REQ-023 SHALL, on a simultaneous drain and accept, replace out_data and out_src with the new beat and keep out_valid = 1, giving full throughput of 1 beat per cycle.
REQ-024 SHALL, on out_valid && !out_ready, hold out_data, out_src and out_valid stable and deassert both readies.
REQ-025 SHALL update last_grant only on an accepted beat.
REQ-026 SHALL keep a_ready and b_ready independent of out_ready combinationally only through accept; there SHALL be no path from a_data or b_data to any ready.
REQ-027 SHALL increment xfer_cnt by 1 per accepted beat, wrapping from 16'hFFFF to 0.
REQ-028 SHALL keep the arbiter state machine at two states, PREF_A and PREF_B, with state equal to the source preferred at the next tie; the transition occurs on accepted beats only.

Reset
REQ-029 SHALL, while rst_n = 0, immediately force out_valid = 0, out_data = 0, out_src = 0, xfer_cnt = 0, and state = PREF_A.
REQ-030 SHALL, on reset asserted mid-transfer, discard the held beat, so that no beat is emitted after reset release until a new accept.
REQ-031 SHALL hold a_ready and b_ready low while rst_n = 0.

Structure
REQ-032 SHALL place the arbiter state enum (PREF_A, PREF_B) and the source encoding constants (SRC_A = 0, SRC_B = 1) in a shared package.
REQ-033 SHALL instantiate the existing 2:1 mux module as its sole sub-module, with WIDTH passed through and sel driving its select.

Verification
REQ-034 SHALL verify reset: assert rst_n = 0 mid-beat -> out_valid = 0, xfer_cnt = 0 at once; the first tie after release grants A.
REQ-035 SHALL verify a single source: a_valid = 1, a_data = 8'h3C, out_ready = 1 -> a_ready = 1 and sel = 0; the next cycle gives out_data = 8'h3C, out_src = 0, out_valid = 1.
REQ-036 SHALL verify a tie: both sources valid for 4 cycles with out_ready = 1 -> grants A, B, A, B, sel = 0, 1, 0, 1, and xfer_cnt = 4.
REQ-037 SHALL verify backpressure: out_valid = 1 with out_ready = 0 for 3 cycles -> a_ready = b_ready = 0 and out_data stable; on out_ready = 1 the same cycle accepts the next beat.
REQ-038 SHALL verify wrap-around: preload xfer_cnt to 16'hFFFF by 65535 beats, then one more beat -> xfer_cnt = 0.
REQ-039 SHALL verify B alone after an A grant: b_valid = 1, b_data = 8'hA5 -> sel = 1, out_src = 1, out_data = 8'hA5, and last_grant becomes B.
